// File: rtl/matrix_pkg.sv
// ============================================================================
// Module      : matrix_pkg
// Description : Shared constants, byte classes, error codes and parser state
//               encoding for the matrix input path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

    // Largest legal row/column count and element value
    localparam int MAX_DIM  = 5;
    localparam int ELEM_MAX = 99;

    // Accumulator width: holds any legal value, check is done one bit wider
    localparam int ACC_W = 10;

    // ASCII constants
    localparam logic [7:0] c_ASCII_SPACE = 8'h20;
    localparam logic [7:0] c_ASCII_CR    = 8'h0D;
    localparam logic [7:0] c_ASCII_LF    = 8'h0A;
    localparam logic [7:0] c_ASCII_ZERO  = 8'h30;
    localparam logic [7:0] c_ASCII_NINE  = 8'h39;

    // Error code reported on input_error
    typedef enum logic [1:0] {
        ERR_SHORT    = 2'd0,
        ERR_BAD_CHAR = 2'd1,
        ERR_BAD_DIM  = 2'd2,
        ERR_RANGE    = 2'd3
    } err_code_e;

    // Classification of a received byte
    typedef enum logic [1:0] {
        CLS_DIGIT = 2'd0,
        CLS_SPACE = 2'd1,
        CLS_TERM  = 2'd2,
        CLS_BAD   = 2'd3
    } byte_class_e;

    // Parser state encoding
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ROW  = 3'd1,
        S_GET_COL  = 3'd2,
        S_GET_ELEM = 3'd3,
        S_FILL     = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_e;

    // A dimension token is legal when it lies in 1..MAX_DIM
    function automatic logic dim_ok(input logic [ACC_W-1:0] v);
        return (v != '0) && (v <= ACC_W'(MAX_DIM));
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_input_parser_ascii_classifier.sv
// ============================================================================
// Module      : ascii_classifier
// Description : Combinational byte classifier: digit / space / terminator /
//               bad, plus the 4-bit value of a digit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_classifier
    import matrix_pkg::*;
(
    input  logic [7:0]  i_data,
    output byte_class_e o_class,
    output logic [3:0]  o_digit
);

    // Map the byte to its class; digit value is only meaningful for CLS_DIGIT
    always_comb begin
        o_class = CLS_BAD;
        o_digit = 4'd0;
        if ((i_data >= c_ASCII_ZERO) && (i_data <= c_ASCII_NINE)) begin
            o_class = CLS_DIGIT;
            o_digit = i_data[3:0];
        end else if (i_data == c_ASCII_SPACE) begin
            o_class = CLS_SPACE;
        end else if ((i_data == c_ASCII_CR) || (i_data == c_ASCII_LF)) begin
            o_class = CLS_TERM;
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_input_parser.sv
// ============================================================================
// Module      : matrix_input_parser
// Description : Parses "rows cols e0 e1 ..." from a UART byte stream and
//               writes each element row-major into the matrix store.
//               Optional feature macro MATRIX_INPUT_ZERO_FILL_EN: a short
//               entry zero-fills the remaining addresses instead of erroring.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_input_parser
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       input_start,
    input  logic [1:0] target_id,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [1:0] wr_id,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [2:0] row_num,
    output logic [2:0] col_num,
    output logic       input_busy,
    output logic       input_done,
    output logic       input_error,
    output logic [1:0] err_code
);

    state_e         r_state;
    state_e         w_state_nxt;

    logic [ACC_W-1:0] r_acc;
    logic             r_has_digit;
    logic [4:0]       r_elem_cnt;
    logic [2:0]       r_row;
    logic [2:0]       r_col;
    logic [1:0]       r_id;
    err_code_e        r_err_code;
    logic             r_wr_en;
    logic [4:0]       r_wr_addr;
    logic [7:0]       r_wr_data;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_has_digit_nxt;
    logic [4:0]       w_elem_cnt_nxt;
    logic [2:0]       w_row_nxt;
    logic [2:0]       w_col_nxt;
    logic [1:0]       w_id_nxt;
    err_code_e        w_err_nxt;
    logic             w_wr_en_nxt;
    logic [4:0]       w_wr_addr_nxt;
    logic [7:0]       w_wr_data_nxt;
    logic             w_done_nxt;
    logic             w_error_nxt;

    byte_class_e      w_class;
    logic [3:0]       w_digit;
    logic [ACC_W:0]   w_acc_ext;
    logic [5:0]       w_total;
    logic [5:0]       w_elem_inc;
    logic             w_is_term;

    ascii_classifier u_classifier (
        .i_data  (rx_data),
        .o_class (w_class),
        .o_digit (w_digit)
    );

    // One bit wider than the accumulator so an overflowing value is seen, not wrapped
    assign w_acc_ext  = ({1'b0, r_acc} * (ACC_W + 1)'(10)) + {{(ACC_W - 3){1'b0}}, w_digit};
    assign w_total    = 6'(r_row) * 6'(r_col);
    assign w_elem_inc = {1'b0, r_elem_cnt} + 6'd1;
    assign w_is_term  = (w_class == CLS_TERM);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for the whole parser datapath
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_has_digit_nxt = r_has_digit;
        w_elem_cnt_nxt  = r_elem_cnt;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_id_nxt        = r_id;
        w_err_nxt       = r_err_code;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_done_nxt      = 1'b0;
        w_error_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Bytes arriving in IDLE, including one coincident with start, are dropped
                if (input_start) begin
                    w_state_nxt     = S_GET_ROW;
                    w_id_nxt        = target_id;
                    w_elem_cnt_nxt  = 5'd0;
                    w_acc_nxt       = '0;
                    w_has_digit_nxt = 1'b0;
                    w_err_nxt       = ERR_SHORT;
                end
            end

            S_GET_ROW, S_GET_COL, S_GET_ELEM: begin
                if (rx_valid) begin
                    case (w_class)
                        CLS_DIGIT: begin
                            if (w_acc_ext > (ACC_W + 1)'(ELEM_MAX)) begin
                                w_state_nxt = S_ERR;
                                w_err_nxt   = ERR_RANGE;
                            end else begin
                                w_acc_nxt       = w_acc_ext[ACC_W-1:0];
                                w_has_digit_nxt = 1'b1;
                            end
                        end

                        CLS_SPACE, CLS_TERM: begin
                            // Separators without a pending token are skipped
                            if (r_has_digit) begin
                                w_acc_nxt       = '0;
                                w_has_digit_nxt = 1'b0;
                                if (r_state == S_GET_ROW) begin
                                    if (!dim_ok(r_acc)) begin
                                        w_state_nxt = S_ERR;
                                        w_err_nxt   = ERR_BAD_DIM;
                                    end else begin
                                        w_row_nxt = r_acc[2:0];
                                        // Column count unknown, so nothing to fill
                                        if (w_is_term) begin
                                            w_state_nxt = S_ERR;
                                            w_err_nxt   = ERR_SHORT;
                                        end else begin
                                            w_state_nxt = S_GET_COL;
                                        end
                                    end
                                end else if (r_state == S_GET_COL) begin
                                    if (!dim_ok(r_acc)) begin
                                        w_state_nxt = S_ERR;
                                        w_err_nxt   = ERR_BAD_DIM;
                                    end else begin
                                        w_col_nxt = r_acc[2:0];
                                        if (w_is_term) begin
`ifdef MATRIX_INPUT_ZERO_FILL_EN
                                            w_state_nxt = S_FILL;
`else
                                            w_state_nxt = S_ERR;
                                            w_err_nxt   = ERR_SHORT;
`endif
                                        end else begin
                                            w_state_nxt = S_GET_ELEM;
                                        end
                                    end
                                end else begin
                                    w_wr_en_nxt    = 1'b1;
                                    w_wr_addr_nxt  = r_elem_cnt;
                                    w_wr_data_nxt  = r_acc[7:0];
                                    w_elem_cnt_nxt = w_elem_inc[4:0];
                                    if (w_elem_inc == w_total) begin
                                        w_state_nxt = S_DONE;
                                    end else if (w_is_term) begin
`ifdef MATRIX_INPUT_ZERO_FILL_EN
                                        w_state_nxt = S_FILL;
`else
                                        w_state_nxt = S_ERR;
                                        w_err_nxt   = ERR_SHORT;
`endif
                                    end
                                end
                            end
                        end

                        default: begin
                            w_state_nxt = S_ERR;
                            w_err_nxt   = ERR_BAD_CHAR;
                        end
                    endcase
                end
            end

`ifdef MATRIX_INPUT_ZERO_FILL_EN
            S_FILL: begin
                // One zero write per cycle until the matrix is complete
                w_wr_en_nxt    = 1'b1;
                w_wr_addr_nxt  = r_elem_cnt;
                w_wr_data_nxt  = 8'd0;
                w_elem_cnt_nxt = w_elem_inc[4:0];
                if (w_elem_inc >= w_total) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif

            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            S_ERR: begin
                w_error_nxt = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; busy follows the next state so it falls with done/error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_has_digit <= 1'b0;
            r_elem_cnt  <= 5'd0;
            r_row       <= 3'd0;
            r_col       <= 3'd0;
            r_id        <= 2'd0;
            r_err_code  <= ERR_SHORT;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_wr_data   <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_has_digit <= w_has_digit_nxt;
            r_elem_cnt  <= w_elem_cnt_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_id        <= w_id_nxt;
            r_err_code  <= w_err_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_id       = r_id;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign row_num     = r_row;
    assign col_num     = r_col;
    assign input_busy  = r_busy;
    assign input_done  = r_done;
    assign input_error = r_error;
    assign err_code    = r_err_code;

endmodule

`default_nettype wire
